// File: rtl/p12_grid_loader.sv
// Grid bitstream loader: streams words from a valid/ready source into the grid
// scan chain for the enabled passes (v, h, d planes, then state), capturing readback.
module p12_grid_loader #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    pass_mask,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic          g_se,
  output logic          g_sc,
  output logic [1:0]    g_cfg_lbc,
  output logic          g_ff_gate,
  input  logic          g_out_sc,
  output logic [DW-1:0] rb_data,
  output logic          rb_valid
);

  localparam int NBITS = WIDTH * HEIGHT;
  localparam int PCW   = $clog2(NBITS + 1);
  localparam int BCW   = $clog2(DW + 1);
  localparam logic [PCW-1:0] PASS_LAST  = PCW'(NBITS - 1);
  localparam logic [BCW-1:0] WORD_LAST  = BCW'(DW - 1);
  localparam logic [1:0]     STATE_PASS = 2'd3;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DONE} state_t;

  state_t         state, state_d;
  logic [3:0]     pend;       // remaining passes, index 0..3 = v, h, d, state
  logic [1:0]     cur_pass;
  logic [DW-1:0]  wbuf;
  logic [BCW-1:0] bit_cnt;
  logic [PCW-1:0] pass_cnt;
  logic [DW-1:0]  rb_acc;
  logic [BCW-1:0] rb_cnt;

  logic [3:0]    order_mask;
  logic [3:0]    rest_mask;
  logic [DW-1:0] rb_next;
  logic          pass_end;
  logic          word_end;

  function automatic logic [1:0] first_pass(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Reorder the mask into load order so the lowest set bit is always the next pass.
  assign order_mask = {pass_mask[0], pass_mask[3], pass_mask[2], pass_mask[1]};
  assign rest_mask  = pend & ~(4'b0001 << cur_pass);
  assign pass_end   = (state == SHIFT) && (pass_cnt == PASS_LAST);
  assign word_end   = (state == SHIFT) && (bit_cnt == WORD_LAST);
  assign rb_next    = rb_acc | (DW'(g_out_sc) << rb_cnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    g_se      = 1'b0;
    g_sc      = 1'b0;
    g_cfg_lbc = 2'd0;
    g_ff_gate = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        g_ff_gate = 1'b1;
        if (start) state_d = (order_mask == 4'd0) ? DONE : FETCH;
      end
      FETCH: begin
        s_ready = 1'b1;
        g_se    = 1'b1;
        if (s_valid) state_d = SHIFT;
      end
      SHIFT: begin
        g_se      = 1'b1;
        g_ff_gate = 1'b1;
        g_sc      = wbuf[0];
        if (pass_end) begin
          if (cur_pass != STATE_PASS) state_d = LATCH;
          else                        state_d = DONE;
        end else if (word_end) begin
          state_d = FETCH;
        end
      end
      LATCH: begin
        g_se      = 1'b1;
        g_cfg_lbc = cur_pass + 2'd1;
        state_d   = (pend != 4'd0) ? FETCH : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      cur_pass <= '0;
      wbuf     <= '0;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      rb_acc   <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pend     <= order_mask;
          cur_pass <= first_pass(order_mask);
          pass_cnt <= '0;
        end
        FETCH: if (s_valid) begin
          wbuf    <= s_data;
          bit_cnt <= '0;
        end
        SHIFT: begin
          wbuf    <= wbuf >> 1;
          bit_cnt <= bit_cnt + BCW'(1);
          if (pass_end) begin
            pass_cnt <= '0;
            pend     <= rest_mask;
          end else begin
            pass_cnt <= pass_cnt + PCW'(1);
          end
          // Flush readback on a full word or at pass end; partial words are zero-padded.
          if (pass_end || word_end) begin
            rb_data  <= rb_next;
            rb_valid <= 1'b1;
            rb_acc   <= '0;
            rb_cnt   <= '0;
          end else begin
            rb_acc <= rb_next;
            rb_cnt <= rb_cnt + BCW'(1);
          end
        end
        LATCH: cur_pass <= first_pass(pend);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_p12_grid_loader.sv
// Self-checking bench for p12_grid_loader: default 8x8/DW=8 instance plus a
// 3x3/DW=4 instance with g_out_sc tied high, checked against a stream-level model.
module tb_p12_grid_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, s_valid, g_out_sc;
  logic [3:0] pass_mask;
  logic [7:0] s_data;
  bit         sel;       // 0 observes/drives the default instance, 1 the small one
  int         nbits, dw;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] rb_hold;

  always #5 clk = ~clk;

  logic       a_s_ready, a_busy, a_done, a_g_se, a_g_sc, a_g_ff_gate, a_rb_valid;
  logic [1:0] a_g_cfg_lbc;
  logic [7:0] a_rb_data;
  logic       b_s_ready, b_busy, b_done, b_g_se, b_g_sc, b_g_ff_gate, b_rb_valid;
  logic [1:0] b_g_cfg_lbc;
  logic [3:0] b_rb_data;
  logic       start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  p12_grid_loader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pass_mask(pass_mask),
    .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
    .busy(a_busy), .done(a_done), .g_se(a_g_se), .g_sc(a_g_sc),
    .g_cfg_lbc(a_g_cfg_lbc), .g_ff_gate(a_g_ff_gate), .g_out_sc(g_out_sc),
    .rb_data(a_rb_data), .rb_valid(a_rb_valid)
  );

  p12_grid_loader #(.WIDTH(3), .HEIGHT(3), .DW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pass_mask(pass_mask),
    .s_data(s_data[3:0]), .s_valid(s_valid), .s_ready(b_s_ready),
    .busy(b_busy), .done(b_done), .g_se(b_g_se), .g_sc(b_g_sc),
    .g_cfg_lbc(b_g_cfg_lbc), .g_ff_gate(b_g_ff_gate), .g_out_sc(1'b1),
    .rb_data(b_rb_data), .rb_valid(b_rb_valid)
  );

  logic       s_ready, busy, done, g_se, g_sc, g_ff_gate, rb_valid;
  logic [1:0] g_cfg_lbc;
  logic [7:0] rb_data;

  assign s_ready   = sel ? b_s_ready   : a_s_ready;
  assign busy      = sel ? b_busy      : a_busy;
  assign done      = sel ? b_done      : a_done;
  assign g_se      = sel ? b_g_se      : a_g_se;
  assign g_sc      = sel ? b_g_sc      : a_g_sc;
  assign g_ff_gate = sel ? b_g_ff_gate : a_g_ff_gate;
  assign g_cfg_lbc = sel ? b_g_cfg_lbc : a_g_cfg_lbc;
  assign rb_valid  = sel ? b_rb_valid  : a_rb_valid;
  assign rb_data   = sel ? {4'd0, b_rb_data} : a_rb_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {busy, done, s_ready, rb_valid, g_se, g_sc, g_cfg_lbc, g_ff_gate},
          9'b0_0_0_0_0_0_00_1);
    check({tag, "_rb"}, rb_data, 32'd0);
  endtask

  // One load sequence. Tokens: 0/1 = shifted bit, 10+lbc = latch cycle, 20 = done.
  task automatic run_load(input logic [3:0] mask, input int stall_pct, input int abort_at,
                          input bit mid_start, input bit inc_words);
    int         exp_tok[$], obs_tok[$], exp_rb[$], obs_rb[$];
    logic [7:0] words[$];
    bit         rbbits[$];
    int         order[4] = '{1, 2, 3, 0};
    int         wpp, npass, wi, nshift, nfetch, nstall, done_cyc, prev_fetch, pi, acc, b;
    logic [7:0] wmask;
    bit         done_seen;
    wmask = 8'((1 << dw) - 1);
    wpp = (nbits + dw - 1) / dw;
    nshift = 0; nfetch = 0; nstall = 0; done_cyc = -1; prev_fetch = 0; done_seen = 0;
    pass_mask = mask; start = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pass_mask = 4'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 0) check("busy_after_start", busy, 1'b1);
      if (rb_valid) begin
        obs_rb.push_back(int'(rb_data));
        rb_hold = rb_data;
      end else begin
        check("rb_hold", rb_data, rb_hold);
      end
      if (done) begin
        check("done_busy", busy, 1'b1);
        check("done_not_after_fetch", prev_fetch, 0);
        obs_tok.push_back(20);
        done_cyc = cyc; done_seen = 1; start = 1'b0;
        @(negedge clk);
        break;
      end
      prev_fetch = s_ready;
      if (s_ready) begin
        nfetch++;
        check("fetch_ctl", {g_se, g_ff_gate, g_cfg_lbc, busy}, 5'b1_0_00_1);
      end else if (g_ff_gate) begin
        check("shift_ctl", {g_se, g_cfg_lbc, busy}, 4'b1_00_1);
        obs_tok.push_back(int'(g_sc));
        nshift++;
      end else begin
        check("latch_ctl", {g_se, busy}, 2'b11);
        obs_tok.push_back(10 + int'(g_cfg_lbc));
      end
      s_valid  = ($urandom_range(99) >= stall_pct);
      s_data   = inc_words ? 8'(words.size() + 1) : 8'($urandom);
      g_out_sc = 1'($urandom);
      if (s_ready && s_valid) words.push_back(s_data & wmask);
      if (s_ready && !s_valid) nstall++;
      if (!s_ready && g_ff_gate) rbbits.push_back(sel ? 1'b1 : g_out_sc);
      if (mid_start) begin
        start = 1'($urandom_range(1));
        pass_mask = 4'($urandom);
      end
      if (abort_at > 0 && !s_ready && g_ff_gate && nshift == abort_at) begin
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        check_idle("abort_idle");
        b = 0;
        foreach (obs_tok[i]) if (obs_tok[i] >= 10) b++;
        check("abort_no_latch_done", b, 0);
        rb_hold = 8'd0;
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("after_done", {busy, done, s_ready, g_se, g_ff_gate, g_cfg_lbc}, 7'b000_0_1_00);
    if (mask == 4'd0) check("empty_mask_done_cycle", done_cyc, 0);

    // Reference: passes in order v, h, d, state; each consumes wpp fresh words.
    npass = 0; wi = 0;
    for (int p = 0; p < 4; p++) begin
      if (!mask[order[p]]) continue;
      acc = 0;
      for (int c = 0; c < nbits; c++) begin
        pi = wi + c / dw;
        b  = (pi < words.size()) ? int'((words[pi] >> (c % dw)) & 8'd1) : 0;
        exp_tok.push_back(b);
        b  = (npass * nbits + c < rbbits.size()) ? int'(rbbits[npass * nbits + c]) : 0;
        acc |= b << (c % dw);
        if ((c % dw) == dw - 1 || c == nbits - 1) begin
          exp_rb.push_back(acc);
          acc = 0;
        end
      end
      if (p < 3) exp_tok.push_back(10 + p + 1);
      wi += wpp;
      npass++;
    end
    exp_tok.push_back(20);

    check("words_used", words.size(), npass * wpp);
    check("shift_count", nshift, npass * nbits);
    check("fetch_count", nfetch, words.size() + nstall);
    check("tok_len", obs_tok.size(), exp_tok.size());
    foreach (exp_tok[i]) begin
      if (i >= obs_tok.size()) break;
      check($sformatf("tok[%0d]", i), obs_tok[i], exp_tok[i]);
      if (obs_tok[i] != exp_tok[i]) break;
    end
    check("rb_len", obs_rb.size(), exp_rb.size());
    foreach (exp_rb[i]) begin
      if (i >= obs_rb.size()) break;
      check($sformatf("rb[%0d]", i), obs_rb[i], exp_rb[i]);
      if (obs_rb[i] != exp_rb[i]) break;
    end
  endtask

  initial begin
    sel = 1'b0; nbits = 64; dw = 8;
    rst_n = 1'b0; start = 1'b0; pass_mask = 4'd0; s_valid = 1'b0; s_data = 8'd0;
    g_out_sc = 1'b0; rb_hold = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_a");
    sel = 1'b1;
    #1 check_idle("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_no_start");

    run_load(4'b0001, 0, -1, 0, 1);   // state pass, words 0x01..0x08
    run_load(4'b1010, 0, -1, 0, 0);   // v then d plane
    run_load(4'b0000, 0, -1, 0, 0);   // empty mask
    run_load(4'b0100, 40, -1, 1, 0);  // stalls, start/mask toggled mid-pass
    for (int k = 0; k < 3; k++) run_load(4'($urandom_range(1, 15)), 30, -1, 1, 0);
    run_load(4'b1111, 10, 30, 1, 0);  // reset on shift 30
    run_load(4'b1111, 0, -1, 0, 0);   // complete load after abort

    sel = 1'b1; nbits = 9; dw = 4; rb_hold = 8'd0;
    @(negedge clk);
    run_load(4'b0001, 0, -1, 0, 0);   // readback 0xF, 0xF, 0x1
    run_load(4'b1011, 30, -1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
